// File: rtl/unpack_16to12.sv
// Purpose : restore 12-bit pixels from 16-bit packed words (4 pixels per 3 words); rewrite header image_type.
// Latency : 2 cycles dvi->dvo with an empty FIFO (push, then registered pop).
// Backpressure: none; output pops every cycle, and entries that find the FIFO full are dropped and flagged.
//
// Ports:
//   clk, resetb          clock, async active-low reset
//   enable               unpack enable (async; synchronised, then latched at FRAME_START)
//   dvi, dtypei, datai   input word strobe, data type, packed word / header / control data
//   dvo, dtypeo, datao   output strobe, data type, pixel in [11:0] (upper nibble 0) or passthrough data
//   overflow             sticky flag: an entry was dropped because the FIFO was full
module unpack_16to12 #(
    parameter int                     FIFO_DEPTH         = 4,
    parameter logic [4:0]             RAW_IMAGE_TYPE     = 5'h00,
    parameter int                     DTYPE_WIDTH        = 8,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = 8'h01,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END    = 8'h02,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_START = 8'h04,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_END   = 8'h08,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_HEADER       = 8'h10,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK   = 8'hC0,
    // header word index holding the image_type field
    parameter logic [7:0]             IMAGE_TYPE_ADDR    = 8'd2
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   enable,
    input  logic                   dvi,
    input  logic [DTYPE_WIDTH-1:0] dtypei,
    input  logic [15:0]            datai,
    output logic                   dvo,
    output logic [DTYPE_WIDTH-1:0] dtypeo,
    output logic [15:0]            datao,
    output logic                   overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = AW + 2;
    localparam int EW = DTYPE_WIDTH + 16;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        HEADER
    } state_t;

    state_t state_q, state_d;

    logic          en_meta, en_sync;
    logic          en_lat, en_lat_d;
    logic [1:0]    ph_q, ph_d;
    logic [7:0]    res_q, res_d;
    logic [7:0]    hdr_q, hdr_d;

    logic          pix_word;
    logic          unpack;
    logic [1:0]    push_n;
    logic [EW-1:0] ent0, ent1;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          pop;
    logic [FW-1:0] free;
    logic [1:0]    acc_n;
    logic          drop;

    // ------------------------------------------------------------------
    // Framing FSM: state follows the control dtypes seen on dvi.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        en_lat_d = en_lat;
        if (dvi) begin
            if (dtypei == DTYPE_FRAME_START) begin
                state_d  = FRAME;
                en_lat_d = en_sync;
            end else if (dtypei == DTYPE_HEADER_START) begin
                state_d = HEADER;
            end else if (dtypei == DTYPE_FRAME_END || dtypei == DTYPE_HEADER_END) begin
                state_d = IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Unpack / rewrite datapath: produces 0, 1 or 2 FIFO entries per cycle.
    // ------------------------------------------------------------------
    assign pix_word = dvi && (|(dtypei & DTYPE_PIXEL_MASK));
    assign unpack   = en_lat && (state_q == FRAME) && pix_word;

    always_comb begin
        ph_d   = ph_q;
        res_d  = res_q;
        hdr_d  = hdr_q;
        push_n = 2'd0;
        ent0   = {dtypei, datai};
        ent1   = {dtypei, 4'h0, datai[11:0]};

        if (state_q != HEADER) begin
            hdr_d = 8'd0;
        end else if (dvi && dtypei == DTYPE_HEADER) begin
            hdr_d = hdr_q + 8'd1;
        end

        // Any cycle outside an enabled frame forgets the group position.
        if (!en_lat || state_q != FRAME) begin
            ph_d = 2'd0;
        end

        if (unpack) begin
            case (ph_q)
                2'd0: begin
                    ent0       = {dtypei, 4'h0, datai[15:4]};
                    res_d[3:0] = datai[3:0];
                    push_n     = 2'd1;
                    ph_d       = 2'd1;
                end
                2'd1: begin
                    ent0   = {dtypei, 4'h0, datai[15:8], res_q[3:0]};
                    res_d  = datai[7:0];
                    push_n = 2'd1;
                    ph_d   = 2'd2;
                end
                2'd2: begin
                    // Last word of a group yields p2 then p3 in the same cycle.
                    ent0   = {dtypei, 4'h0, datai[15:12], res_q};
                    ent1   = {dtypei, 4'h0, datai[11:0]};
                    push_n = 2'd2;
                    ph_d   = 2'd0;
                end
                default: begin
                    push_n = 2'd1;
                    ph_d   = 2'd0;
                end
            endcase
        end else if (dvi) begin
            push_n = 2'd1;
            if (en_lat && state_q == HEADER && dtypei == DTYPE_HEADER &&
                hdr_q == IMAGE_TYPE_ADDR) begin
                ent0 = {dtypei, (datai & 16'hFFE0) | {11'h000, RAW_IMAGE_TYPE}};
            end
        end

        // A partial group left at frame end is discarded here.
        if (dvi && (dtypei == DTYPE_FRAME_START || dtypei == DTYPE_FRAME_END)) begin
            ph_d = 2'd0;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO: up to 2 writes and 1 read per cycle. Free space counts
    // the slot vacated by this cycle's pop; excess entries drop from the
    // tail, so p3 goes before p2.
    // ------------------------------------------------------------------
    assign pop  = (count_q != '0);
    assign free = FW'(FIFO_DEPTH) - FW'(count_q) + FW'(pop);

    always_comb begin
        acc_n = push_n;
        drop  = 1'b0;
        if (FW'(push_n) > free) begin
            acc_n = free[1:0];
            drop  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_n != 2'd0) begin
            mem[wr_ptr] <= ent0;
        end
        if (acc_n == 2'd2) begin
            mem[wr_ptr + AW'(1)] <= ent1;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            en_meta  <= 1'b0;
            en_sync  <= 1'b0;
            en_lat   <= 1'b0;
            state_q  <= IDLE;
            ph_q     <= 2'd0;
            res_q    <= 8'd0;
            hdr_q    <= 8'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
            dvo      <= 1'b0;
            dtypeo   <= '0;
            datao    <= 16'd0;
        end else begin
            en_meta <= enable;
            en_sync <= en_meta;
            en_lat  <= en_lat_d;
            state_q <= state_d;
            ph_q    <= ph_d;
            res_q   <= res_d;
            hdr_q   <= hdr_d;
            wr_ptr  <= wr_ptr + AW'(acc_n);
            rd_ptr  <= rd_ptr + AW'(pop);
            count_q <= count_q + CW'(acc_n) - CW'(pop);
            if (drop) begin
                overflow <= 1'b1;
            end
            dvo <= pop;
            if (pop) begin
                {dtypeo, datao} <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_unpack_16to12.sv
// Purpose : directed check of unpack_16to12 framing, unpacking, header rewrite, overflow and reset.
// Latency : expects 2 cycles dvi->dvo with an empty FIFO.
// Backpressure: none; outputs are collected every cycle by a monitor.
module tb_unpack_16to12;

    localparam logic [7:0] DT_FS  = 8'h01;
    localparam logic [7:0] DT_FE  = 8'h02;
    localparam logic [7:0] DT_HS  = 8'h04;
    localparam logic [7:0] DT_HE  = 8'h08;
    localparam logic [7:0] DT_HDR = 8'h10;
    localparam logic [7:0] DT_PIX = 8'h40;

    logic        clk    = 1'b0;
    logic        resetb = 1'b0;
    logic        enable = 1'b0;
    logic        dvi    = 1'b0;
    logic [7:0]  dtypei = 8'h00;
    logic [15:0] datai  = 16'h0000;
    logic        dvo;
    logic [7:0]  dtypeo;
    logic [15:0] datao;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0;

    logic [23:0] got_q[$];
    int          got_cyc[$];
    logic [23:0] exp_q[$];

    unpack_16to12 dut (
        .clk      (clk),
        .resetb   (resetb),
        .enable   (enable),
        .dvi      (dvi),
        .dtypei   (dtypei),
        .datai    (datai),
        .dvo      (dvo),
        .dtypeo   (dtypeo),
        .datao    (datao),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dvo === 1'b1) begin
            got_q.push_back({dtypeo, datao});
            got_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] dt, input logic [15:0] d);
        dvi    = 1'b1;
        dtypei = dt;
        datai  = d;
        @(posedge clk);
        #1;
        dvi    = 1'b0;
        dtypei = 8'h00;
        datai  = 16'h0000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [7:0] dt, input logic [15:0] d);
        exp_q.push_back({dt, d});
    endtask

    task automatic send_group();
        send(DT_PIX, 16'h1236);
        send(DT_PIX, 16'h4589);
        send(DT_PIX, 16'h7ABC);
    endtask

    task automatic expect_group();
        expect_out(DT_PIX, 16'h0123);
        expect_out(DT_PIX, 16'h0456);
        expect_out(DT_PIX, 16'h0789);
        expect_out(DT_PIX, 16'h0ABC);
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, " count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d]", tag, i), {8'h00, got_q[i]}, {8'h00, exp_q[i]});
        end
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic chk_latency(input string tag);
        if (got_cyc.size() > 0) begin
            chk(tag, got_cyc[0] - t0, 2);
        end else begin
            chk(tag, -1, 2);
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst dvo", dvo, 1'b0);
        chk("rst dtypeo", dtypeo, 8'h00);
        chk("rst datao", datao, 16'h0000);
        chk("rst overflow", overflow, 1'b0);
        resetb = 1'b1;
        idle(2);

        // 1: full group unpacked
        enable = 1'b1;
        idle(4);
        got_q.delete();
        got_cyc.delete();
        t0 = cyc;
        send(DT_FS, 16'h00F0);
        send_group();
        send(DT_FE, 16'h000F);
        idle(8);
        chk_latency("t1 latency");
        if (got_cyc.size() >= 5) begin
            chk("t1 pixel span", got_cyc[4] - got_cyc[1], 3);
        end else begin
            chk("t1 pixel span", got_cyc.size(), 5);
        end
        chk("t1 overflow", overflow, 1'b0);
        expect_out(DT_FS, 16'h00F0);
        expect_group();
        expect_out(DT_FE, 16'h000F);
        compare("t1");

        // 3: header rewrite (en_lat=1 from the previous frame start)
        send(DT_HS, 16'h0001);
        send(DT_HDR, 16'hAAAA);
        send(DT_HDR, 16'h5555);
        send(DT_HDR, 16'h1230);
        send(DT_HDR, 16'h123F);
        send(DT_HE, 16'h0002);
        idle(8);
        expect_out(DT_HS, 16'h0001);
        expect_out(DT_HDR, 16'hAAAA);
        expect_out(DT_HDR, 16'h5555);
        expect_out(DT_HDR, 16'h1220);
        expect_out(DT_HDR, 16'h123F);
        expect_out(DT_HE, 16'h0002);
        compare("t3");

        // 4: truncated group, next frame restarts at phase 0
        send(DT_FS, 16'h00F0);
        send(DT_PIX, 16'h1236);
        send(DT_PIX, 16'h4589);
        send(DT_FE, 16'h000F);
        send(DT_FS, 16'h00F1);
        send_group();
        send(DT_FE, 16'h000E);
        idle(8);
        expect_out(DT_FS, 16'h00F0);
        expect_out(DT_PIX, 16'h0123);
        expect_out(DT_PIX, 16'h0456);
        expect_out(DT_FE, 16'h000F);
        expect_out(DT_FS, 16'h00F1);
        expect_group();
        expect_out(DT_FE, 16'h000E);
        compare("t4");

        // 2: enable low -> passthrough
        enable = 1'b0;
        idle(4);
        t0 = cyc;
        send(DT_FS, 16'h00F0);
        send_group();
        send(DT_FE, 16'h000F);
        idle(8);
        chk_latency("t2 latency");
        expect_out(DT_FS, 16'h00F0);
        expect_out(DT_PIX, 16'h1236);
        expect_out(DT_PIX, 16'h4589);
        expect_out(DT_PIX, 16'h7ABC);
        expect_out(DT_FE, 16'h000F);
        compare("t2");

        // 5: sustained pixel words until the FIFO overflows (p3 of group 4 dropped)
        enable = 1'b1;
        idle(4);
        send(DT_FS, 16'h00F0);
        send_group();
        send_group();
        send_group();
        send(DT_PIX, 16'h1236);
        send(DT_PIX, 16'h4589);
        chk("t5 overflow before", overflow, 1'b0);
        send(DT_PIX, 16'h7ABC);
        chk("t5 overflow after", overflow, 1'b1);
        send(DT_FE, 16'h000F);
        idle(8);
        chk("t5 overflow sticky", overflow, 1'b1);
        expect_out(DT_FS, 16'h00F0);
        expect_group();
        expect_group();
        expect_group();
        expect_out(DT_PIX, 16'h0123);
        expect_out(DT_PIX, 16'h0456);
        expect_out(DT_PIX, 16'h0789);
        expect_out(DT_FE, 16'h000F);
        compare("t5");

        // 6: reset in the cycle after W2
        send(DT_FS, 16'h00F0);
        send_group();
        resetb = 1'b0;
        got_q.delete();
        got_cyc.delete();
        @(negedge clk);
        chk("t6 dvo", dvo, 1'b0);
        chk("t6 overflow", overflow, 1'b0);
        resetb = 1'b1;
        idle(8);
        compare("t6");

        // Recovery after reset
        idle(4);
        send(DT_FS, 16'h00F0);
        send_group();
        send(DT_FE, 16'h000F);
        idle(8);
        expect_out(DT_FS, 16'h00F0);
        expect_group();
        expect_out(DT_FE, 16'h000F);
        compare("t6 recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
